// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: owns an 8080-style 8-bit LCD write bus and shares it between
// a command/parameter port ({rs, byte} words) and an RGB565 pixel port.
// Each pixel is sent as two bytes (high byte first). Once the first pixel of a
// frame is accepted, the bus stays locked to the pixel port until FRAME_PIXELS
// pixels have gone out.
// Optional build macro: LCD_TE_SYNC_EN. When it is defined, the first pixel of
// each frame waits for a rising edge on the panel's tearing-effect (lcd_fmark)
// line. When it is undefined, lcd_fmark is ignored.
module lcd_bus_arbiter #(
  parameter int WR_LOW_CYCLES  = 1,
  parameter int WR_HIGH_CYCLES = 1,
  parameter int FRAME_PIXELS   = 76800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [8:0]  cmd_data,
  output logic        cmd_ready,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  input  logic        lcd_fmark,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_wr,
  output logic        busy,
  output logic        frame_done
);

  localparam int TMAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  // Keep at least one bit so that FRAME_PIXELS=1 still elaborates. In that
  // case the counter simply stays at zero.
  localparam int CW   = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  localparam logic [TW-1:0] LO_LAST  = TW'(WR_LOW_CYCLES - 1);
  localparam logic [TW-1:0] HI_LAST  = TW'(WR_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t        state;
  logic          byte_sel;
  logic          is_pix;
  logic [TW-1:0] timer;
  logic [CW-1:0] pix_cnt;
  // Only the low byte has to survive the accept cycle. The high byte goes
  // straight onto lcd_data.
  logic [7:0]    pix_lo;

  logic idle;
  logic cnt_zero;
  logic te_ok;
  logic cmd_acc;
  logic pix_acc;

  assign idle     = (state == IDLE);
  assign cnt_zero = (pix_cnt == '0);

  // Readies are forced low while reset is asserted, so the port never
  // advertises space during reset.
  assign cmd_ready = rst_n & idle & cnt_zero;
  assign pix_ready = rst_n & idle & (~cnt_zero | ~cmd_valid) & te_ok;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign pix_acc   = pix_valid & pix_ready;
  assign busy      = ~idle | ~cnt_zero;

`ifdef LCD_TE_SYNC_EN
  logic [2:0] te_sync;
  logic       te_armed;

  // Synchronise lcd_fmark and arm on its rising edge. The arm is consumed by
  // the first pixel of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      te_sync  <= 3'b000;
      te_armed <= 1'b0;
    end else begin
      te_sync  <= {te_sync[1:0], lcd_fmark};
      te_armed <= (te_armed & ~(pix_acc & cnt_zero)) | (te_sync[1] & ~te_sync[2]);
    end
  end

  assign te_ok = ~cnt_zero | te_armed;
`else
  logic unused_fmark;
  assign unused_fmark = lcd_fmark;
  assign te_ok = 1'b1;
`endif

  // Bus FSM. It accepts one word, then generates strobe timing, then sends the
  // second byte of a pixel if there is one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_sel   <= 1'b0;
      is_pix     <= 1'b0;
      timer      <= '0;
      pix_cnt    <= '0;
      pix_lo     <= 8'h00;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b1;
      lcd_wr     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            lcd_rs   <= cmd_data[8];
            lcd_data <= cmd_data[7:0];
            lcd_wr   <= 1'b0;
            is_pix   <= 1'b0;
            byte_sel <= 1'b0;
            timer    <= '0;
            state    <= WR_LO;
          end else if (pix_acc) begin
            pix_lo   <= pix_data[7:0];
            lcd_rs   <= 1'b1;
            lcd_data <= pix_data[15:8];
            lcd_wr   <= 1'b0;
            is_pix   <= 1'b1;
            byte_sel <= 1'b0;
            timer    <= '0;
            state    <= WR_LO;
            pix_cnt  <= (pix_cnt == CNT_LAST) ? '0 : pix_cnt + CW'(1);
          end
        end
        WR_LO: begin
          if (timer == LO_LAST) begin
            lcd_wr <= 1'b1;
            timer  <= '0;
            state  <= WR_HI;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WR_HI: begin
          if (timer == HI_LAST) begin
            timer <= '0;
            if (is_pix && !byte_sel) begin
              lcd_data <= pix_lo;
              byte_sel <= 1'b1;
              lcd_wr   <= 1'b0;
              state    <= WR_LO;
            end else begin
              state      <= IDLE;
              frame_done <= is_pix & cnt_zero;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter, default build with the TE sync feature off.
// The reference model keeps a queue of expected bus "slots": one entry per
// cycle, describing what the wire must show. Readies and busy are derived from
// whether that queue is empty and from the frame pixel count.
module tb_lcd_bus_arbiter;
  localparam int L  = 1;
  localparam int H  = 1;
  localparam int FP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [8:0]  cmd_data = '0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        lcd_fmark = 1'b0;
  logic        cmd_ready, pix_ready, lcd_rs, lcd_wr, busy, frame_done;
  logic [7:0]  lcd_data;

  lcd_bus_arbiter #(.WR_LOW_CYCLES(L), .WR_HIGH_CYCLES(H), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .lcd_fmark(lcd_fmark),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic       rs;
    logic [7:0] data;
    logic       frame_end;
  } slot_t;

  slot_t      q[$];
  int         m_cnt;
  logic [7:0] m_data;
  logic       m_rs;
  logic       m_done;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       cmd_hs, pix_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_data = 8'h00;
    m_rs   = 1'b1;
    m_done = 1'b0;
  endtask

  // One bus byte: L cycles with the strobe low, then H cycles with it high.
  task automatic push_byte(input logic rs, input logic [7:0] data, input logic fe);
    for (int i = 0; i < L; i++) q.push_back('{1'b0, rs, data, 1'b0});
    for (int i = 0; i < H; i++) q.push_back('{1'b1, rs, data, (fe && i == H - 1)});
  endtask

  // Drive the inputs for one cycle, compare every output with the model, then
  // advance the model across the next rising edge.
  task automatic step(input logic cv, input logic [8:0] cd, input logic pv, input logic [15:0] pd);
    logic  e_idle, e_cr, e_pr;
    slot_t s;
    @(negedge clk);
    cmd_valid = cv;
    cmd_data  = cd;
    pix_valid = pv;
    pix_data  = pd;
    lcd_fmark = 1'($urandom_range(0, 1));
    #1;
    e_idle = (q.size() == 0);
    e_cr   = e_idle && (m_cnt == 0);
    e_pr   = e_idle && ((m_cnt != 0) || !cv);
    chk("lcd_wr",     lcd_wr,     e_idle ? 1'b1 : q[0].wr);
    chk("lcd_rs",     lcd_rs,     e_idle ? m_rs : q[0].rs);
    chk("lcd_data",   lcd_data,   e_idle ? m_data : q[0].data);
    chk("cmd_ready",  cmd_ready,  e_cr);
    chk("pix_ready",  pix_ready,  e_pr);
    chk("busy",       busy,       !e_idle || (m_cnt != 0));
    chk("frame_done", frame_done, m_done);
    cmd_hs = cv && e_cr;
    pix_hs = pv && e_pr;
    m_done = 1'b0;
    if (!e_idle) begin
      s      = q.pop_front();
      m_rs   = s.rs;
      m_data = s.data;
      m_done = s.frame_end;
    end else if (cmd_hs) begin
      push_byte(cd[8], cd[7:0], 1'b0);
    end else if (pix_hs) begin
      m_cnt = (m_cnt + 1) % FP;
      push_byte(1'b1, pd[15:8], 1'b0);
      push_byte(1'b1, pd[7:0], (m_cnt == 0));
    end
    cyc++;
  endtask

  initial begin
    int n_pix;
    int k_cmd;
    logic [7:0] snap_data[0:3];
    logic       snap_wr[0:3];

    model_reset();
    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_lcd_wr", lcd_wr, 1'b1);
    chk("rst_lcd_rs", lcd_rs, 1'b1);
    chk("rst_lcd_data", lcd_data, 8'h00);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;

    // Idle after release: both ports are ready.
    step(1'b0, 9'h000, 1'b0, 16'h0000);
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_pix_ready", pix_ready, 1'b1);

    // Single command word 0x0EF.
    step(1'b1, 9'h0EF, 1'b0, 16'h0000);
    chk("cmd_accept", cmd_hs, 1'b1);
    step(1'b0, 9'h000, 1'b0, 16'h0000);
    chk("cmd_wr_low", lcd_wr, 1'b0);
    chk("cmd_rs", lcd_rs, 1'b0);
    chk("cmd_data", lcd_data, 8'hEF);
    step(1'b0, 9'h000, 1'b0, 16'h0000);
    chk("cmd_wr_high", lcd_wr, 1'b1);
    chk("cmd_data_held", lcd_data, 8'hEF);
    step(1'b0, 9'h000, 1'b0, 16'h0000);
    chk("cmd_ready_again", cmd_ready, 1'b1);

    // Back-to-back pixels: 5-cycle cadence, so one whole frame takes 20 cycles.
    n_pix = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 9'h000, 1'b1, 16'hF800);
      if (pix_hs) n_pix++;
      if (i >= 1 && i <= 4) begin
        snap_data[i-1] = lcd_data;
        snap_wr[i-1]   = lcd_wr;
      end
    end
    chk("pix_count_20cyc", n_pix, 4);
    chk("pix_hi_byte", snap_data[0], 8'hF8);
    chk("pix_hi_wr", snap_wr[0], 1'b0);
    chk("pix_gap_wr", snap_wr[1], 1'b1);
    chk("pix_lo_byte", snap_data[2], 8'h00);
    chk("pix_lo_wr", snap_wr[2], 1'b0);
    step(1'b0, 9'h000, 1'b0, 16'h0000);
    chk("pix_frame_done", frame_done, 1'b1);

    // Frame lock: the command is raised after pixel 1 and must wait for the
    // frame to end. Then it must beat the waiting pixel.
    step(1'b0, 9'h000, 1'b1, 16'h1234);
    n_pix = pix_hs ? 1 : 0;
    k_cmd = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 9'h12C, 1'b1, 16'h5678);
      if (cmd_hs) begin
        k_cmd = k;
        chk("lock_done_at_cmd", frame_done, 1'b1);
        chk("lock_pix_blocked", pix_hs, 1'b0);
        break;
      end
      if (pix_hs) n_pix++;
    end
    chk("lock_cmd_cycle", k_cmd, 20);
    chk("lock_pix_count", n_pix, 4);
    repeat (4) step(1'b0, 9'h000, 1'b0, 16'h0000);

    // Reset in the middle of a byte. The strobe must return high immediately,
    // and the open frame is discarded.
    step(1'b0, 9'h000, 1'b1, 16'hABCD);
    step(1'b0, 9'h000, 1'b0, 16'h0000);
    chk("mid_wr_low", lcd_wr, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", lcd_wr, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 9'h02A, 1'b1, 16'h9999);
    chk("post_rst_cmd_accept", cmd_hs, 1'b1);
    step(1'b0, 9'h000, 1'b0, 16'h0000);
    chk("post_rst_cmd_data", lcd_data, 8'h2A);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), 9'($urandom), ($urandom_range(0, 1) == 1), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
